// File: rtl/uart_fifo_bridge_if.sv
// UART-side link of uart_fifo_bridge.
//   t_data   : byte presented to the UART transmitter
//   t_valid  : one-cycle transmit strobe
//   tx_ready : UART transmitter can accept a byte
//   r_data   : received byte, valid while rx_ready=1
//   rx_ready : one-cycle strobe, r_data holds a new byte
// master = bridge side, slave = UART side.
interface uart_fifo_bridge_if;
  logic [7:0] t_data;
  logic       t_valid;
  logic       tx_ready;
  logic [7:0] r_data;
  logic       rx_ready;

  modport master (output t_data, output t_valid,
                  input  tx_ready, input r_data, input rx_ready);
  modport slave  (input  t_data, input t_valid,
                  output tx_ready, output r_data, output rx_ready);
endinterface

// File: rtl/uart_fifo_bridge.sv
// Byte buffer between core I/O and the UART wrapper.
// A TX FIFO is drained into the UART via a one-cycle t_valid strobe followed
// by a guard window that ignores tx_ready.
// An RX FIFO captures rx_ready strobes and records drops in a sticky flag.
// Ports:
//   clk, rst              : clock and synchronous active-high reset
//   tx_wr_en/tx_wr_data   : push into the TX FIFO (dropped when tx_full)
//   tx_full, tx_count     : TX FIFO status
//   rx_rd_en/rx_rd_data   : pop and first-word-fall-through head of RX FIFO
//   rx_empty, rx_count    : RX FIFO status
//   rx_overflow, ovf_clr  : sticky drop flag and its clear
//   uart                  : UART link (master modport)
module uart_fifo_bridge #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned TX_GUARD   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_wr_en,
  input  logic [7:0]            tx_wr_data,
  output logic                  tx_full,
  output logic [DEPTH_LOG2:0]   tx_count,
  input  logic                  rx_rd_en,
  output logic [7:0]            rx_rd_data,
  output logic                  rx_empty,
  output logic [DEPTH_LOG2:0]   rx_count,
  output logic                  rx_overflow,
  input  logic                  ovf_clr,
  uart_fifo_bridge_if.master    uart
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [3:0] GUARD_LOAD = 4'(TX_GUARD);

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;
  typedef enum logic {TX_IDLE, TX_GUARD_ST} tx_state_t;

  // ---------------- TX FIFO ----------------
  logic [7:0] tx_mem [DEPTH];
  ptr_t       tx_wr_ptr, tx_rd_ptr;
  cnt_t       tx_cnt;
  logic       tx_push, tx_pop;

  assign tx_full  = (tx_cnt == FULL_CNT);
  assign tx_count = tx_cnt;
  assign tx_push  = tx_wr_en && !tx_full;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= tx_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_cnt    <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + ptr_t'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + ptr_t'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + cnt_t'(1);
        2'b01:   tx_cnt <= tx_cnt - cnt_t'(1);
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_t  state_q, state_d;
  logic [3:0] guard_q, guard_d;
  logic       t_valid_q, t_valid_d;
  logic [7:0] t_data_q, t_data_d;

  always_comb begin
    state_d   = state_q;
    guard_d   = guard_q;
    t_valid_d = 1'b0;
    t_data_d  = t_data_q;
    tx_pop    = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (uart.tx_ready && (tx_cnt != '0)) begin
          tx_pop    = 1'b1;
          t_valid_d = 1'b1;
          t_data_d  = tx_mem[tx_rd_ptr];
          guard_d   = GUARD_LOAD;
          state_d   = TX_GUARD_ST;
        end
      end
      TX_GUARD_ST: begin
        guard_d = guard_q - 4'd1;
        if (guard_q == 4'd1) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      guard_q   <= '0;
      t_valid_q <= 1'b0;
      t_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      guard_q   <= guard_d;
      t_valid_q <= t_valid_d;
      t_data_q  <= t_data_d;
    end
  end

  assign uart.t_valid = t_valid_q;
  assign uart.t_data  = t_data_q;

  // ---------------- RX FIFO ----------------
  logic [7:0] rx_mem [DEPTH];
  ptr_t       rx_wr_ptr, rx_rd_ptr;
  cnt_t       rx_cnt;
  logic       rx_push, rx_pop, rx_drop, rx_ovf_q;

  assign rx_empty    = (rx_cnt == '0);
  assign rx_count    = rx_cnt;
  assign rx_overflow = rx_ovf_q;
  assign rx_rd_data  = rx_empty ? '0 : rx_mem[rx_rd_ptr];
  assign rx_pop      = rx_rd_en && !rx_empty;
  // When full, a same-cycle pop frees the slot the write lands in
  // (wr_ptr == rd_ptr), so the head is read out before it is overwritten.
  assign rx_push     = uart.rx_ready && ((rx_cnt != FULL_CNT) || rx_pop);
  assign rx_drop     = uart.rx_ready && (rx_cnt == FULL_CNT) && !rx_pop;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= uart.r_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_cnt    <= '0;
      rx_ovf_q  <= 1'b0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + ptr_t'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + ptr_t'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + cnt_t'(1);
        2'b01:   rx_cnt <= rx_cnt - cnt_t'(1);
        default: rx_cnt <= rx_cnt;
      endcase
      if (rx_drop)      rx_ovf_q <= 1'b1;
      else if (ovf_clr) rx_ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
module tb_uart_fifo_bridge;
  logic       clk = 1'b0;
  logic       rst;
  logic       tx_wr_en;
  logic [7:0] tx_wr_data;
  logic       tx_full;
  logic [4:0] tx_count;
  logic       rx_rd_en;
  logic [7:0] rx_rd_data;
  logic       rx_empty;
  logic [4:0] rx_count;
  logic       rx_overflow;
  logic       ovf_clr;

  always #5 clk = ~clk;

  uart_fifo_bridge_if u_if ();

  uart_fifo_bridge #(.DEPTH_LOG2(4), .TX_GUARD(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_wr_en   (tx_wr_en),
    .tx_wr_data (tx_wr_data),
    .tx_full    (tx_full),
    .tx_count   (tx_count),
    .rx_rd_en   (rx_rd_en),
    .rx_rd_data (rx_rd_data),
    .rx_empty   (rx_empty),
    .rx_count   (rx_count),
    .rx_overflow(rx_overflow),
    .ovf_clr    (ovf_clr),
    .uart       (u_if.master)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  int strobe_cyc[$];
  int cyc_n = 0;
  int last_strobe = -100;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples on the falling edge, pops scoreboard queues.
  initial begin
    forever begin
      @(negedge clk);
      cyc_n++;
      if (u_if.t_valid) begin
        check("t_valid_width", int'(prev_valid), 0);
        check("strobe_gap_ok", int'((cyc_n - last_strobe) >= 3), 1);
        if (tx_exp.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe: got t_data 0x%0h expected no strobe", u_if.t_data);
        end else begin
          check("t_data", int'(u_if.t_data), int'(tx_exp.pop_front()));
        end
        strobe_cyc.push_back(cyc_n);
        last_strobe = cyc_n;
      end
      prev_valid = u_if.t_valid;
      if (rx_rd_en && !rx_empty) begin
        if (rx_exp.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rx_pop: got 0x%0h expected no data", rx_rd_data);
        end else begin
          check("rx_rd_data", int'(rx_rd_data), int'(rx_exp.pop_front()));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic found;
    rst = 1'b1; tx_wr_en = 1'b0; tx_wr_data = '0; rx_rd_en = 1'b0; ovf_clr = 1'b0;
    u_if.tx_ready = 1'b0; u_if.r_data = '0; u_if.rx_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_tx_count", int'(tx_count), 0);
    check("rst_rx_count", int'(rx_count), 0);
    check("rst_rx_empty", int'(rx_empty), 1);
    check("rst_tx_full", int'(tx_full), 0);
    check("rst_t_valid", int'(u_if.t_valid), 0);
    check("rst_t_data", int'(u_if.t_data), 0);
    check("rst_rx_rd_data", int'(rx_rd_data), 0);
    check("rst_rx_overflow", int'(rx_overflow), 0);

    // TX drain: three consecutive writes, tx_ready high
    u_if.tx_ready = 1'b1;
    strobe_cyc.delete();
    tx_wr_en = 1'b1; tx_wr_data = 8'h41; tx_exp.push_back(8'h41);
    tick();
    tx_wr_data = 8'h42; tx_exp.push_back(8'h42);
    tick();
    check("drain_first_valid", int'(u_if.t_valid), 1);
    check("drain_first_data", int'(u_if.t_data), 8'h41);
    tx_wr_data = 8'h43; tx_exp.push_back(8'h43);
    tick();
    tx_wr_en = 1'b0;
    repeat (12) tick();
    check("drain_tx_count", int'(tx_count), 0);
    check("drain_strobes", strobe_cyc.size(), 3);
    if (strobe_cyc.size() == 3) begin
      check("drain_gap1", strobe_cyc[1] - strobe_cyc[0], 3);
      check("drain_gap2", strobe_cyc[2] - strobe_cyc[1], 3);
    end

    // TX full: 16 writes with tx_ready low, 17th dropped
    u_if.tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tx_wr_en = 1'b1; tx_wr_data = 8'(i); tx_exp.push_back(8'(i));
      tick();
    end
    tx_wr_en = 1'b0;
    check("full_tx_full", int'(tx_full), 1);
    check("full_tx_count", int'(tx_count), 16);
    tx_wr_en = 1'b1; tx_wr_data = 8'hFF;
    tick();
    tx_wr_en = 1'b0;
    check("full_drop_count", int'(tx_count), 16);
    strobe_cyc.delete();
    u_if.tx_ready = 1'b1;
    repeat (16 * 3 + 6) tick();
    check("full_drain_count", int'(tx_count), 0);
    check("full_drain_strobes", strobe_cyc.size(), 16);
    check("full_queue_left", tx_exp.size(), 0);

    // RX overflow: 17 strobes, no reads; ovf_clr on the dropping cycle
    for (int i = 0; i < 17; i++) begin
      u_if.rx_ready = 1'b1; u_if.r_data = 8'(8'h10 + i);
      if (i < 16) rx_exp.push_back(8'(8'h10 + i));
      ovf_clr = (i == 16);
      tick();
    end
    u_if.rx_ready = 1'b0; ovf_clr = 1'b0;
    check("ovf_rx_count", int'(rx_count), 16);
    check("ovf_set", int'(rx_overflow), 1);
    check("ovf_head", int'(rx_rd_data), 8'h10);
    rx_rd_en = 1'b1;
    repeat (16) tick();
    rx_rd_en = 1'b0;
    check("ovf_rx_empty", int'(rx_empty), 1);
    check("ovf_empty_data", int'(rx_rd_data), 0);
    check("ovf_sticky", int'(rx_overflow), 1);
    rx_rd_en = 1'b1;
    tick();
    rx_rd_en = 1'b0;
    check("empty_read_count", int'(rx_count), 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", int'(rx_overflow), 0);

    // RX full with simultaneous push and pop
    for (int i = 0; i < 16; i++) begin
      u_if.rx_ready = 1'b1; u_if.r_data = 8'(8'h60 + i); rx_exp.push_back(8'(8'h60 + i));
      tick();
    end
    u_if.rx_ready = 1'b1; u_if.r_data = 8'h55; rx_exp.push_back(8'h55); rx_rd_en = 1'b1;
    tick();
    u_if.rx_ready = 1'b0; rx_rd_en = 1'b0;
    check("simul_rx_count", int'(rx_count), 16);
    check("simul_no_ovf", int'(rx_overflow), 0);
    rx_rd_en = 1'b1;
    repeat (16) tick();
    rx_rd_en = 1'b0;
    check("simul_rx_empty", int'(rx_empty), 1);
    check("simul_queue_left", rx_exp.size(), 0);

    // Reset mid-transmit
    u_if.tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tx_wr_en = 1'b1; tx_wr_data = 8'(8'hA0 + i); tx_exp.push_back(8'(8'hA0 + i));
      tick();
    end
    tx_wr_en = 1'b0;
    u_if.tx_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      if (u_if.t_valid) found = 1'b1;
    end
    check("mid_strobe_seen", int'(found), 1);
    check("mid_queued", int'(tx_count), 5);
    rst = 1'b1;
    @(negedge clk);
    #1;
    tx_exp.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_t_valid", int'(u_if.t_valid), 0);
    check("mid_tx_count", int'(tx_count), 0);
    strobe_cyc.delete();
    repeat (20) tick();
    check("mid_no_strobes", strobe_cyc.size(), 0);
    check("mid_tx_count_end", int'(tx_count), 0);

    check("end_tx_queue", tx_exp.size(), 0);
    check("end_rx_queue", rx_exp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
